// File: rtl/ahb3lite_csr_ext.sv
// AHB3-Lite CSR slave with per-register access modes, wait states,
// two-cycle ERROR responses and per-register read/write strobes.
module ahb3lite_csr_ext #(
    parameter int CNT         = 4,
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 0,
    parameter int ERROR_EN    = 1
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [31:0]       HWDATA,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [1:0]        HTRANS,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    input  logic [3*CNT-1:0]  ACCESS,
    input  logic [32*CNT-1:0] REGIN,
    output logic [32*CNT-1:0] REGOUT,
    output logic [CNT-1:0]    WR_STB,
    output logic [CNT-1:0]    RD_STB
);

    localparam int IW = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        dv_q, dw_q, dill_q;
    logic [IW-1:0] didx_q;
    logic [3:0]  dbe_q;

    logic [31:0] regs_q [CNT];
    logic [31:0] regs_d [CNT];
    logic [CNT-1:0] wstb_q, rstb_q;
    logic [CNT-1:0] hit;

    logic        acc;
    logic [IW-1:0] a_idx;
    logic [2:0]  a_mode;
    logic [3:0]  a_be;
    logic        a_inr, a_mis, a_rowr, a_ill;
    logic        commit, wr_c, rd_c;
    logic [31:0] mask;

    logic unused;
    assign unused = ^{HBURST, HPROT, HADDR, HTRANS[0]};

    // Address-phase decode
    assign acc   = HSEL & HREADY & HTRANS[1];
    assign a_idx = HADDR[ADDR_W-1:2];
    assign a_inr = int'(a_idx) < CNT;

    always_comb begin
        a_mode = 3'b001;
        for (int n = 0; n < CNT; n++) begin
            if (a_idx == IW'(n)) a_mode = ACCESS[3*n +: 3];
        end
    end

    always_comb begin
        a_be = 4'hF;
        unique case (1'b1)
            HSIZE == 3'd0: a_be = 4'b0001 << HADDR[1:0];
            HSIZE == 3'd1: a_be = HADDR[1] ? 4'b1100 : 4'b0011;
            default:       a_be = 4'hF;
        endcase
    end

    assign a_mis  = (HSIZE == 3'd1 && HADDR[0]) ||
                    (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    // RO, RC and both reserved encodings reject writes
    assign a_rowr = HWRITE && (a_mode == 3'b001 || a_mode == 3'b101 ||
                               a_mode[2:1] == 2'b11);
    assign a_ill  = !a_inr || HSIZE > 3'd2 || a_mis || a_rowr;

    // FSM: state register
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (HREADYOUT) begin
            state_d = S_IDLE;
            if (acc) begin
                if (a_ill && ERROR_EN != 0) begin
                    state_d = S_ERR1;
                end else if (WAIT_STATES != 0) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
        end else if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // FSM: outputs
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            S_WAIT: HREADYOUT = (cnt_q == 4'd0);
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2: HRESP = 1'b1;
            default: ;
        endcase
    end

    // Data-phase context, replaced whenever the bus advances
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            dv_q   <= 1'b0;
            dw_q   <= 1'b0;
            dill_q <= 1'b0;
            didx_q <= '0;
            dbe_q  <= '0;
        end else if (HREADYOUT) begin
            dv_q <= acc;
            if (acc) begin
                dw_q   <= HWRITE;
                dill_q <= a_ill;
                didx_q <= a_idx;
                dbe_q  <= a_be;
            end
        end
    end

    assign commit = dv_q & HREADYOUT & ~dill_q;
    assign wr_c   = commit & dw_q;
    assign rd_c   = commit & ~dw_q;
    assign mask   = {{8{dbe_q[3]}}, {8{dbe_q[2]}},
                     {8{dbe_q[1]}}, {8{dbe_q[0]}}};

    always_comb begin
        for (int n = 0; n < CNT; n++) hit[n] = (didx_q == IW'(n));
    end

    always_comb begin
        for (int n = 0; n < CNT; n++) begin
            regs_d[n] = regs_q[n];
            case (ACCESS[3*n +: 3])
                3'b000, 3'b010: begin
                    if (wr_c && hit[n])
                        regs_d[n] = (regs_q[n] & ~mask) | (HWDATA & mask);
                end
                3'b011: begin
                    if (wr_c && hit[n])
                        regs_d[n] = (regs_q[n] & ~(HWDATA & mask)) |
                                    REGIN[32*n +: 32];
                    else
                        regs_d[n] = regs_q[n] | REGIN[32*n +: 32];
                end
                3'b100: begin
                    regs_d[n] = (wr_c && hit[n]) ? (HWDATA & mask) : '0;
                end
                3'b101: begin
                    if (rd_c && hit[n])
                        regs_d[n] = REGIN[32*n +: 32];
                    else
                        regs_d[n] = regs_q[n] | REGIN[32*n +: 32];
                end
                default: regs_d[n] = REGIN[32*n +: 32];
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            for (int n = 0; n < CNT; n++) begin
                regs_q[n] <= (ACCESS[3*n +: 3] == 3'b100) ?
                             32'h0 : REGIN[32*n +: 32];
            end
            wstb_q <= '0;
            rstb_q <= '0;
        end else begin
            regs_q <= regs_d;
            wstb_q <= wr_c ? hit : '0;
            rstb_q <= rd_c ? hit : '0;
        end
    end

    always_comb begin
        HRDATA = 32'h0;
        if (rd_c) begin
            for (int n = 0; n < CNT; n++) begin
                if (hit[n]) begin
                    case (ACCESS[3*n +: 3])
                        3'b000, 3'b011, 3'b101: HRDATA = regs_q[n];
                        3'b001, 3'b110, 3'b111: HRDATA = REGIN[32*n +: 32];
                        default:                HRDATA = 32'h0;
                    endcase
                end
            end
        end
    end

    always_comb begin
        for (int n = 0; n < CNT; n++) REGOUT[32*n +: 32] = regs_q[n];
    end

    assign WR_STB = wstb_q;
    assign RD_STB = rstb_q;

endmodule

// File: tb/tb_ahb3lite_csr_ext.sv
// Directed bench for ahb3lite_csr_ext: one zero-wait ERROR-enabled bank
// and one two-wait-state bank with silent handling of illegal transfers.
module tb_ahb3lite_csr_ext;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hsel_a, hsel_b;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        tgt;

    logic [31:0]  rdata_a, rdata_b;
    logic         rdy_a, rdy_b, resp_a, resp_b;
    logic [17:0]  access_a;
    logic [191:0] regin_a, regout_a;
    logic [5:0]   wstb_a, rstb_a;
    logic [11:0]  access_b;
    logic [127:0] regin_b, regout_b;
    logic [3:0]   wstb_b, rstb_b;

    logic        hr, resp;
    logic [31:0] rdata;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] rd;
    logic        r0, r1;
    int          low;

    always #5 clk = ~clk;

    assign hr    = tgt ? rdy_b : rdy_a;
    assign resp  = tgt ? resp_b : resp_a;
    assign rdata = tgt ? rdata_b : rdata_a;

    // idx5 WO, idx4 W1S, idx3 RO, idx2 RC, idx1 W1C, idx0 RW
    assign access_a = {3'b010, 3'b100, 3'b001, 3'b101, 3'b011, 3'b000};
    assign access_b = '0;

    ahb3lite_csr_ext #(
        .CNT(6), .ADDR_W(12), .WAIT_STATES(0), .ERROR_EN(1)
    ) u_a (
        .CLK(clk), .RESETn(rstn), .HSEL(hsel_a), .HADDR(haddr),
        .HWDATA(hwdata), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(3'b000), .HPROT(4'h3), .HTRANS(htrans), .HREADY(rdy_a),
        .HRDATA(rdata_a), .HREADYOUT(rdy_a), .HRESP(resp_a),
        .ACCESS(access_a), .REGIN(regin_a), .REGOUT(regout_a),
        .WR_STB(wstb_a), .RD_STB(rstb_a)
    );

    ahb3lite_csr_ext #(
        .CNT(4), .ADDR_W(12), .WAIT_STATES(2), .ERROR_EN(0)
    ) u_b (
        .CLK(clk), .RESETn(rstn), .HSEL(hsel_b), .HADDR(haddr),
        .HWDATA(hwdata), .HWRITE(hwrite), .HSIZE(hsize),
        .HBURST(3'b001), .HPROT(4'h1), .HTRANS(htrans), .HREADY(rdy_b),
        .HRDATA(rdata_b), .HREADYOUT(rdy_b), .HRESP(resp_b),
        .ACCESS(access_b), .REGIN(regin_b), .REGOUT(regout_b),
        .WR_STB(wstb_b), .RD_STB(rstb_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single transfer; returns first-cycle HRESP, final HRESP/HRDATA and
    // the number of HREADYOUT-low data-phase cycles.
    task automatic xfer(input logic t, input logic [31:0] a,
                        input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rdo,
                        output logic rs0, output logic rs, output int lo);
        tgt    = t;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = 2'b10;
        hsel_a = !t;
        hsel_b = t;
        @(posedge clk); #1;
        htrans = 2'b00;
        hsel_a = 1'b0;
        hsel_b = 1'b0;
        hwdata = wd;
        rs0    = resp;
        lo     = 0;
        while (!hr && lo < 20) begin
            lo++;
            @(posedge clk); #1;
        end
        rdo = rdata;
        rs  = resp;
        @(posedge clk); #1;
    endtask

    initial begin
        rstn = 1'b0;
        tgt = 1'b0;
        hsel_a = 1'b0; hsel_b = 1'b0;
        haddr = '0; hwdata = '0; hwrite = 1'b0;
        hsize = 3'd2; htrans = 2'b00;
        regin_a = '0;
        regin_b = '0;
        regin_a[31:0]    = 32'h1234_5678;
        regin_a[63:32]   = 32'h0000_00F0;
        regin_a[127:96]  = 32'hA5A5_0003;
        regin_a[159:128] = 32'h0000_1111;
        regin_a[191:160] = 32'h0000_0055;
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        regin_a[63:32] = 32'h0;

        chk("rst_regout0", regout_a[31:0], 32'h1234_5678);
        chk("rst_w1c", regout_a[63:32], 32'h0000_00F0);
        chk("rst_w1s", regout_a[159:128], 32'h0);
        chk("rst_ready", {31'b0, rdy_a}, 32'd1);
        chk("rst_resp", {31'b0, resp_a}, 32'd0);
        chk("rst_stb", {20'b0, wstb_a, rstb_a}, 32'd0);
        chk("rst_rdata", rdata_a, 32'h0);

        xfer(1'b0, 32'h0, 1'b0, 3'd2, 32'h0, rd, r0, r1, low);
        chk("rd0_data", rd, 32'h1234_5678);
        chk("rd0_resp", {31'b0, r1}, 32'd0);
        chk("rd0_low", low, 32'd0);
        chk("rd0_rstb", {26'b0, rstb_a}, 32'h01);

        regin_a[63:32] = 32'h10;
        xfer(1'b0, 32'h4, 1'b1, 3'd2, 32'h30, rd, r0, r1, low);
        chk("w1c_val", regout_a[63:32], 32'hD0);
        regin_a[63:32] = 32'h0;
        @(posedge clk); #1;
        chk("w1c_hold", regout_a[63:32], 32'hD0);

        regin_a[95:64] = 32'h08;
        @(posedge clk); #1;
        regin_a[95:64] = 32'h0;
        chk("rc_set", regout_a[95:64], 32'h08);
        xfer(1'b0, 32'h8, 1'b0, 3'd2, 32'h0, rd, r0, r1, low);
        chk("rc_rdata", rd, 32'h08);
        chk("rc_clr", regout_a[95:64], 32'h0);
        chk("rc_rstb", {26'b0, rstb_a}, 32'h04);
        @(posedge clk); #1;
        chk("rc_rstb_once", {26'b0, rstb_a}, 32'h0);

        xfer(1'b0, 32'hC, 1'b1, 3'd2, 32'hFFFF_FFFF, rd, r0, r1, low);
        chk("ro_err1", {31'b0, r0}, 32'd1);
        chk("ro_err2", {31'b0, r1}, 32'd1);
        chk("ro_low", low, 32'd1);
        chk("ro_keep", regout_a[127:96], 32'hA5A5_0003);
        chk("ro_wstb", {26'b0, wstb_a}, 32'h0);

        xfer(1'b0, 32'h18, 1'b0, 3'd2, 32'h0, rd, r0, r1, low);
        chk("oob_err1", {31'b0, r0}, 32'd1);
        chk("oob_err2", {31'b0, r1}, 32'd1);
        chk("oob_low", low, 32'd1);
        chk("oob_rdata", rd, 32'h0);
        chk("oob_rstb", {26'b0, rstb_a}, 32'h0);

        tgt = 1'b0;
        haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2;
        htrans = 2'b10; hsel_a = 1'b1;
        @(posedge clk); #1;
        hwdata = 32'hCAFE_F00D;
        hwrite = 1'b0;
        chk("b2b_nowait", {31'b0, rdy_a}, 32'd1);
        @(posedge clk); #1;
        htrans = 2'b00; hsel_a = 1'b0;
        chk("b2b_rdata", rdata_a, 32'hCAFE_F00D);
        chk("b2b_wstb", {26'b0, wstb_a}, 32'h01);
        @(posedge clk); #1;
        chk("b2b_rstb", {26'b0, rstb_a}, 32'h01);

        xfer(1'b0, 32'h10, 1'b1, 3'd2, 32'h5, rd, r0, r1, low);
        chk("w1s_pulse", regout_a[159:128], 32'h5);
        chk("w1s_wstb", {26'b0, wstb_a}, 32'h10);
        @(posedge clk); #1;
        chk("w1s_clear", regout_a[159:128], 32'h0);

        xfer(1'b0, 32'h16, 1'b1, 3'd1, 32'hBEEF_0000, rd, r0, r1, low);
        chk("wo_hword", regout_a[191:160], 32'hBEEF_0055);
        xfer(1'b0, 32'h14, 1'b0, 3'd2, 32'h0, rd, r0, r1, low);
        chk("wo_rd_zero", rd, 32'h0);

        xfer(1'b1, 32'h1, 1'b1, 3'd0, 32'hABAB_ABAB, rd, r0, r1, low);
        chk("ws_low", low, 32'd2);
        chk("ws_byte", regout_b[31:0], 32'h0000_AB00);
        chk("ws_wstb", {28'b0, wstb_b}, 32'h1);
        @(posedge clk); #1;
        chk("ws_wstb_once", {28'b0, wstb_b}, 32'h0);

        xfer(1'b1, 32'h10, 1'b0, 3'd2, 32'h0, rd, r0, r1, low);
        chk("noerr_resp0", {31'b0, r0}, 32'd0);
        chk("noerr_resp", {31'b0, r1}, 32'd0);
        chk("noerr_rdata", rd, 32'h0);
        xfer(1'b1, 32'h2, 1'b1, 3'd2, 32'hFFFF_FFFF, rd, r0, r1, low);
        chk("noerr_mis", regout_b[31:0], 32'h0000_AB00);
        chk("noerr_wstb", {28'b0, wstb_b}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
